collision_scan_engine: RTL and testbench



---
 rtl/collision_scan_engine.sv | 155 +++++++++++++++
 tb/tb_collision_scan_engine.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scan_engine.sv
// Scans a table of object boxes against one latched mover box, one entry per clock,
// through a 1-cycle-latency read port; reports hit mask, first hit index and hit count.
module collision_scan_engine #(
    parameter int NUM_OBJ      = 16,
    parameter int COORD_W      = 11,
    parameter int OBJ_W        = 32,
    parameter int OBJ_H        = 32,
    parameter int MOVER_W      = 32,
    parameter int MOVER_H      = 32,
    parameter int TOUCH_IS_HIT = 1,
    parameter int IDX_W        = $clog2(NUM_OBJ),
    parameter int CNT_W        = $clog2(NUM_OBJ + 1)
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               start,
    input  logic [COORD_W-1:0] mover_x,
    input  logic [COORD_W-1:0] mover_y,
    output logic               obj_rd_en,
    output logic [IDX_W-1:0]   obj_rd_addr,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic               obj_alive,
    output logic               busy,
    output logic               done,
    output logic               collision,
    output logic [NUM_OBJ-1:0] hit_mask,
    output logic [IDX_W-1:0]   hit_index,
    output logic [CNT_W-1:0]   hit_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

    localparam int EW = COORD_W + 1;
    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_OBJ - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   addr_q, addr_d;
    logic [COORD_W-1:0] mx_q, mx_d;
    logic [COORD_W-1:0] my_q, my_d;
    logic               cmp_valid_q, cmp_valid_d;
    logic [IDX_W-1:0]   cmp_idx_q, cmp_idx_d;
    logic [NUM_OBJ-1:0] hit_mask_q, hit_mask_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [IDX_W-1:0]   hit_index_q, hit_index_d;
    logic               collision_q, collision_d;

    // Box edges extended by one bit so right/bottom edges never wrap at the screen limit
    logic [EW-1:0] m_left, m_right, m_top, m_bottom;
    logic [EW-1:0] o_left, o_right, o_top, o_bottom;
    logic          overlap_incl, overlap_strict, overlap, hit;

    always_comb begin
        m_left   = {1'b0, mx_q};
        m_top    = {1'b0, my_q};
        m_right  = m_left + EW'(MOVER_W);
        m_bottom = m_top + EW'(MOVER_H);
        o_left   = {1'b0, obj_x};
        o_top    = {1'b0, obj_y};
        o_right  = o_left + EW'(OBJ_W);
        o_bottom = o_top + EW'(OBJ_H);

        overlap_incl   = (m_left <= o_right) && (o_left <= m_right) &&
                         (m_top <= o_bottom) && (o_top <= m_bottom);
        overlap_strict = (m_left < o_right) && (o_left < m_right) &&
                         (m_top < o_bottom) && (o_top < m_bottom);
        overlap        = (TOUCH_IS_HIT != 0) ? overlap_incl : overlap_strict;
        hit            = cmp_valid_q && overlap && obj_alive;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mx_d        = mx_q;
        my_d        = my_q;
        cmp_valid_d = (state_q == ISSUE);
        cmp_idx_d   = addr_q;
        hit_mask_d  = hit_mask_q;
        hit_count_d = hit_count_q;
        hit_index_d = hit_index_q;
        collision_d = collision_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mx_d        = mover_x;
                    my_d        = mover_y;
                    addr_d      = '0;
                    hit_mask_d  = '0;
                    hit_count_d = '0;
                    hit_index_d = '0;
                    collision_d = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + IDX_W'(1);
                end
            end
            DRAIN:   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Compare results only ever arrive in ISSUE/DRAIN, never alongside the start-time clear
        if (hit) begin
            hit_mask_d[cmp_idx_q] = 1'b1;
            hit_count_d           = hit_count_q + CNT_W'(1);
            if (!collision_q) begin
                hit_index_d = cmp_idx_q;
                collision_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mx_q        <= '0;
            my_q        <= '0;
            cmp_valid_q <= 1'b0;
            cmp_idx_q   <= '0;
            hit_mask_q  <= '0;
            hit_count_q <= '0;
            hit_index_q <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_idx_q   <= cmp_idx_d;
            hit_mask_q  <= hit_mask_d;
            hit_count_q <= hit_count_d;
            hit_index_q <= hit_index_d;
            collision_q <= collision_d;
        end
    end

    assign obj_rd_en   = (state_q == ISSUE);
    assign obj_rd_addr = addr_q;
    assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign done        = (state_q == FINISH);
    assign collision   = collision_q;
    assign hit_mask    = hit_mask_q;
    assign hit_index   = hit_index_q;
    assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_collision_scan_engine.sv
// Directed bench for collision_scan_engine: inclusive (default) and strict-overlap instances
// scanning the same object table, with hand-computed expected results.
module tb_collision_scan_engine;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [10:0] mover_x = '0, mover_y = '0;

    logic        obj_rd_en, obj_rd_en_s;
    logic [3:0]  obj_rd_addr, obj_rd_addr_s;
    logic [10:0] obj_x = '0, obj_y = '0, obj_x_s = '0, obj_y_s = '0;
    logic        obj_alive = 1'b0, obj_alive_s = 1'b0;
    logic        busy, done, collision, busy_s, done_s, collision_s;
    logic [15:0] hit_mask, hit_mask_s;
    logic [3:0]  hit_index, hit_index_s;
    logic [4:0]  hit_count, hit_count_s;

    logic [10:0] tbl_x [N];
    logic [10:0] tbl_y [N];
    logic        tbl_alive [N];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    collision_scan_engine dut (
        .clk(clk), .resetN(resetN), .start(start), .mover_x(mover_x), .mover_y(mover_y),
        .obj_rd_en(obj_rd_en), .obj_rd_addr(obj_rd_addr), .obj_x(obj_x), .obj_y(obj_y),
        .obj_alive(obj_alive), .busy(busy), .done(done), .collision(collision),
        .hit_mask(hit_mask), .hit_index(hit_index), .hit_count(hit_count)
    );

    collision_scan_engine #(.TOUCH_IS_HIT(0)) dut_strict (
        .clk(clk), .resetN(resetN), .start(start), .mover_x(mover_x), .mover_y(mover_y),
        .obj_rd_en(obj_rd_en_s), .obj_rd_addr(obj_rd_addr_s), .obj_x(obj_x_s), .obj_y(obj_y_s),
        .obj_alive(obj_alive_s), .busy(busy_s), .done(done_s), .collision(collision_s),
        .hit_mask(hit_mask_s), .hit_index(hit_index_s), .hit_count(hit_count_s)
    );

    // Synchronous table RAMs, one per instance, 1-cycle read latency
    always_ff @(posedge clk) begin
        if (obj_rd_en) begin
            obj_x     <= tbl_x[obj_rd_addr];
            obj_y     <= tbl_y[obj_rd_addr];
            obj_alive <= tbl_alive[obj_rd_addr];
        end
        if (obj_rd_en_s) begin
            obj_x_s     <= tbl_x[obj_rd_addr_s];
            obj_y_s     <= tbl_y[obj_rd_addr_s];
            obj_alive_s <= tbl_alive[obj_rd_addr_s];
        end
    end

    task automatic fill_far();
        for (int i = 0; i < N; i++) begin
            tbl_x[i]     = 11'd600;
            tbl_y[i]     = 11'd400;
            tbl_alive[i] = 1'b1;
        end
    endtask

    // Start at cycle T, then observe cycles T+1..T+N+6; mover inputs are scrambled after acceptance
    task automatic run_scan(input logic [10:0] mx, input logic [10:0] my, input int restart_at,
                            output int done_cyc, output int done_num, output int busy_cyc,
                            output int addr_err, output bit clear_ok);
        done_cyc = -1; done_num = 0; busy_cyc = 0; addr_err = 0; clear_ok = 1'b0;
        @(posedge clk); #1;
        mover_x = mx; mover_y = my; start = 1'b1;
        for (int k = 1; k <= N + 6; k++) begin
            @(posedge clk); #1;
            start   = (k == restart_at);
            mover_x = ~mx;
            mover_y = ~my;
            if (k == 1)
                clear_ok = (hit_mask === 16'h0 && hit_count === 5'd0 &&
                            hit_index === 4'd0 && collision === 1'b0);
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) begin
                done_num++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (k <= N) begin
                if (!(obj_rd_en === 1'b1 && obj_rd_addr === 4'(k - 1))) addr_err++;
            end else if (obj_rd_en !== 1'b0) begin
                addr_err++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, collision, hit_mask, hit_index, hit_count, obj_rd_en, obj_rd_addr} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h exp=0",
                     {busy, done, collision, hit_mask, hit_index, hit_count, obj_rd_en, obj_rd_addr});
        end
        resetN = 1'b1;
    endtask

    task automatic test_single_hit();
        int dc, dn, bc, ae; bit cl;
        fill_far();
        tbl_x[3] = 11'd120; tbl_y[3] = 11'd110;
        run_scan(11'd100, 11'd100, 0, dc, dn, bc, ae, cl);
        checks++;
        if (dc != N + 2 || dn != 1) begin
            failures++; $display("[TB] FAIL t1_done_timing got=cyc%0d/n%0d exp=cyc%0d/n1", dc, dn, N + 2);
        end
        checks++;
        if (ae != 0) begin failures++; $display("[TB] FAIL t1_read_addr got=%0d_errors exp=0", ae); end
        checks++;
        if ({collision, hit_mask, hit_index, hit_count} !== {1'b1, 16'h0008, 4'd3, 5'd1}) begin
            failures++;
            $display("[TB] FAIL t1_results got=c%0b m%h i%0d n%0d exp=c1 m0008 i3 n1",
                     collision, hit_mask, hit_index, hit_count);
        end
        checks++;
        if (hit_mask_s !== 16'h0008) begin
            failures++; $display("[TB] FAIL t1_strict_mask got=%h exp=0008", hit_mask_s);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (hit_mask !== 16'h0008 || hit_count !== 5'd1) begin
            failures++; $display("[TB] FAIL t1_hold got=m%h n%0d exp=m0008 n1", hit_mask, hit_count);
        end
    endtask

    task automatic test_no_hit();
        int dc, dn, bc, ae; bit cl;
        fill_far();
        run_scan(11'd0, 11'd0, 0, dc, dn, bc, ae, cl);
        checks++;
        if (!cl) begin failures++; $display("[TB] FAIL t2_clear_on_start got=0 exp=1"); end
        checks++;
        if (bc != N + 1) begin failures++; $display("[TB] FAIL t2_busy_cycles got=%0d exp=%0d", bc, N + 1); end
        checks++;
        if ({collision, hit_mask, hit_index, hit_count} !== '0) begin
            failures++;
            $display("[TB] FAIL t2_results got=c%0b m%h i%0d n%0d exp=all0",
                     collision, hit_mask, hit_index, hit_count);
        end
    endtask

    task automatic test_edge_touch();
        int dc, dn, bc, ae; bit cl;
        fill_far();
        tbl_x[0] = 11'd132; tbl_y[0] = 11'd100;
        run_scan(11'd100, 11'd100, 0, dc, dn, bc, ae, cl);
        checks++;
        if (hit_mask !== 16'h0001 || collision !== 1'b1) begin
            failures++; $display("[TB] FAIL t3_touch_incl got=m%h c%0b exp=m0001 c1", hit_mask, collision);
        end
        checks++;
        if (hit_mask_s !== 16'h0000 || collision_s !== 1'b0) begin
            failures++; $display("[TB] FAIL t3_touch_strict got=m%h c%0b exp=m0000 c0", hit_mask_s, collision_s);
        end
    endtask

    task automatic test_multi_dead();
        int dc, dn, bc, ae; bit cl;
        fill_far();
        tbl_x[2] = 11'd210; tbl_y[2] = 11'd210;
        tbl_x[5] = 11'd220; tbl_y[5] = 11'd220; tbl_alive[5] = 1'b0;
        tbl_x[9] = 11'd190; tbl_y[9] = 11'd190;
        run_scan(11'd200, 11'd200, 0, dc, dn, bc, ae, cl);
        checks++;
        if ({collision, hit_mask, hit_index, hit_count} !== {1'b1, 16'h0204, 4'd2, 5'd2}) begin
            failures++;
            $display("[TB] FAIL t4_results got=c%0b m%h i%0d n%0d exp=c1 m0204 i2 n2",
                     collision, hit_mask, hit_index, hit_count);
        end
    endtask

    task automatic test_screen_edge();
        int dc, dn, bc, ae; bit cl;
        fill_far();
        tbl_x[0] = 11'd2047; tbl_y[0] = 11'd10;
        run_scan(11'd2040, 11'd10, 0, dc, dn, bc, ae, cl);
        checks++;
        if ({hit_mask, hit_index, hit_count} !== {16'h0001, 4'd0, 5'd1}) begin
            failures++;
            $display("[TB] FAIL t5_edge_hit got=m%h i%0d n%0d exp=m0001 i0 n1", hit_mask, hit_index, hit_count);
        end
        tbl_x[0] = 11'd0;
        run_scan(11'd2040, 11'd10, 0, dc, dn, bc, ae, cl);
        checks++;
        if (hit_mask !== 16'h0000 || collision !== 1'b0) begin
            failures++; $display("[TB] FAIL t5_edge_nohit got=m%h c%0b exp=m0000 c0", hit_mask, collision);
        end
    endtask

    task automatic test_back_to_back();
        int dc, dn, bc, ae; bit cl;
        fill_far();
        tbl_x[3] = 11'd120; tbl_y[3] = 11'd110;
        run_scan(11'd100, 11'd100, 5, dc, dn, bc, ae, cl);
        checks++;
        if (dc != N + 2 || dn != 1 || bc != N + 1) begin
            failures++;
            $display("[TB] FAIL t6_restart_busy got=cyc%0d/n%0d/b%0d exp=cyc%0d/n1/b%0d", dc, dn, bc, N + 2, N + 1);
        end
        run_scan(11'd100, 11'd100, N + 2, dc, dn, bc, ae, cl);
        checks++;
        if (dn != 1 || bc != N + 1 || ae != 0) begin
            failures++;
            $display("[TB] FAIL t6_restart_finish got=n%0d/b%0d/ae%0d exp=n1/b%0d/ae0", dn, bc, ae, N + 1);
        end
        checks++;
        if (hit_mask !== 16'h0008 || hit_index !== 4'd3) begin
            failures++; $display("[TB] FAIL t6_restart_results got=m%h i%0d exp=m0008 i3", hit_mask, hit_index);
        end
    endtask

    task automatic test_reset_mid_scan();
        int dn, dc, bc, ae, late_busy;
        bit cl;
        fill_far();
        tbl_x[3] = 11'd120; tbl_y[3] = 11'd110;
        @(posedge clk); #1;
        mover_x = 11'd100; mover_y = 11'd100; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (collision !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL t6_pre_reset got=c%0b b%0b exp=c1 b1", collision, busy);
        end
        resetN = 1'b0;
        #1;
        checks++;
        if ({busy, done, collision, hit_mask, hit_index, hit_count, obj_rd_en, obj_rd_addr} !== '0) begin
            failures++;
            $display("[TB] FAIL t6_async_reset got=%h exp=0",
                     {busy, done, collision, hit_mask, hit_index, hit_count, obj_rd_en, obj_rd_addr});
        end
        dn = 0; late_busy = 0;
        for (int j = 0; j < N + 4; j++) begin
            @(posedge clk); #1;
            if (j == 2) resetN = 1'b1;
            if (done === 1'b1) dn++;
            if (busy === 1'b1) late_busy++;
        end
        checks++;
        if (dn != 0 || late_busy != 0) begin
            failures++; $display("[TB] FAIL t6_no_done_after_reset got=d%0d b%0d exp=d0 b0", dn, late_busy);
        end
        run_scan(11'd100, 11'd100, 0, dc, dn, bc, ae, cl);
        checks++;
        if (dc != N + 2 || {collision, hit_mask, hit_index, hit_count} !== {1'b1, 16'h0008, 4'd3, 5'd1}) begin
            failures++;
            $display("[TB] FAIL t6_scan_after_reset got=cyc%0d m%h i%0d n%0d exp=cyc%0d m0008 i3 n1",
                     dc, hit_mask, hit_index, hit_count, N + 2);
        end
    endtask

    initial begin
        fill_far();
        test_reset();
        test_single_hit();
        test_no_hit();
        test_edge_touch();
        test_multi_dead();
        test_screen_edge();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
